// File: rtl/calc_pkg.sv
// Shared encodings for the 4-bit calculator: entry-stage states and ALU opcodes.
package calc_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_OP   = 2'b01,
    S_B    = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_TWOS = 2'b11;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw pushbutton, accepts a level only after it has been stable
// for DEBOUNCE_CYCLES clocks, and emits a registered one-cycle pulse on each accepted press.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Any cycle where the synchronised level matches restarts the stability window.
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/calc_operand_entry.sv
// Operand/opcode entry sequencer: collects A, OP, B from switches on debounced
// enter presses and commits all ALU inputs atomically.
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] i1,
  output logic [3:0] i2,
  output logic [1:0] ctrl,
  output logic       op_valid,
  output logic [1:0] stage
);

  logic w_ent;
  logic w_clr;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_enter),
    .press   (w_ent)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clear),
    .press   (w_clr)
  );

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_a_sh;
  logic [3:0] w_a_nxt;
  logic [1:0] r_op_sh;
  logic [1:0] w_op_nxt;
  logic [3:0] r_i1;
  logic [3:0] r_i2;
  logic [1:0] r_ctrl;
  logic [3:0] w_i1_nxt;
  logic [3:0] w_i2_nxt;
  logic [1:0] w_ctrl_nxt;
  logic       w_commit;
  logic       r_op_valid;
  logic [1:0] r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_A;
      r_a_sh     <= '0;
      r_op_sh    <= '0;
      r_i1       <= '0;
      r_i2       <= '0;
      r_ctrl     <= OP_ADD;
      r_op_valid <= 1'b0;
      r_stage    <= S_A;
    end else begin
      r_state    <= w_state_nxt;
      r_a_sh     <= w_a_nxt;
      r_op_sh    <= w_op_nxt;
      r_i1       <= w_i1_nxt;
      r_i2       <= w_i2_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_op_valid <= w_commit;
      r_stage    <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a_sh;
    w_op_nxt    = r_op_sh;
    w_i1_nxt    = r_i1;
    w_i2_nxt    = r_i2;
    w_ctrl_nxt  = r_ctrl;
    w_commit    = 1'b0;
    if (w_clr) begin
      w_state_nxt = S_A;
      w_a_nxt     = '0;
      w_op_nxt    = '0;
    end else if (w_ent) begin
      case (r_state)
        S_A: begin
          w_a_nxt     = sw;
          w_state_nxt = S_OP;
        end
        S_OP: begin
          w_op_nxt = sw[1:0];
          // Two's complement is unary: commit straight away with B forced to zero.
          if (sw[1:0] == OP_TWOS) begin
            w_i1_nxt    = r_a_sh;
            w_i2_nxt    = '0;
            w_ctrl_nxt  = OP_TWOS;
            w_commit    = 1'b1;
            w_state_nxt = S_SHOW;
          end else begin
            w_state_nxt = S_B;
          end
        end
        S_B: begin
          w_i1_nxt    = r_a_sh;
          w_i2_nxt    = sw;
          w_ctrl_nxt  = r_op_sh;
          w_commit    = 1'b1;
          w_state_nxt = S_SHOW;
        end
        S_SHOW: w_state_nxt = S_A;
        default: w_state_nxt = S_A;
      endcase
    end
  end

  assign i1       = r_i1;
  assign i2       = r_i2;
  assign ctrl     = r_ctrl;
  assign op_valid = r_op_valid;
  assign stage    = r_stage;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed self-checking bench for calc_operand_entry with a short debounce window.
module tb_calc_operand_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] i1;
  logic [3:0] i2;
  logic [1:0] ctrl;
  logic       op_valid;
  logic [1:0] stage;

  int total = 0;
  int bad   = 0;
  int vcount;
  int seen_b;

  calc_operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .i1        (i1),
    .i2        (i2),
    .ctrl      (ctrl),
    .op_valid  (op_valid),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  // Drive buttons for n cycles, sampling op_valid/stage on the falling edge.
  task automatic hold(input logic en, input logic clr, input int n);
    btn_enter = en;
    btn_clear = clr;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (op_valid === 1'b1) vcount++;
      if (stage === 2'b10) seen_b = 1;
    end
  endtask

  task automatic press_enter(input logic [3:0] v);
    sw = v;
    hold(1'b1, 1'b0, 12);
    hold(1'b0, 1'b0, 10);
  endtask

  task automatic test_reset;
    total++;
    if ({i1, i2, ctrl, op_valid, stage} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got i1=%0d i2=%0d ctrl=%b v=%b stage=%b want all 0",
               i1, i2, ctrl, op_valid, stage);
    end
  endtask

  task automatic test_binary;
    vcount = 0;
    press_enter(4'd3);
    total++;
    if (stage !== 2'b01) begin bad++; $display("FAIL basic_stage_op: got %b want 01", stage); end
    press_enter(4'd0);
    total++;
    if (stage !== 2'b10) begin bad++; $display("FAIL basic_stage_b: got %b want 10", stage); end
    total++;
    if (vcount !== 0) begin bad++; $display("FAIL basic_early_valid: got %0d want 0", vcount); end
    press_enter(4'd5);
    total++;
    if ({i1, i2, ctrl, stage} !== {4'd3, 4'd5, 2'b00, 2'b11}) begin
      bad++;
      $display("FAIL basic_commit: got i1=%0d i2=%0d ctrl=%b stage=%b want 3 5 00 11", i1, i2, ctrl, stage);
    end
    total++;
    if (vcount !== 1) begin bad++; $display("FAIL basic_valid_pulses: got %0d want 1", vcount); end
  endtask

  task automatic test_clear_in_b;
    press_enter(4'd0);
    total++;
    if (stage !== 2'b00) begin bad++; $display("FAIL show_to_a: got %b want 00", stage); end
    vcount = 0;
    press_enter(4'd9);
    press_enter(4'd0);
    sw = 4'd7;
    hold(1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 10);
    total++;
    if ({i1, i2, ctrl, stage} !== {4'd3, 4'd5, 2'b00, 2'b00}) begin
      bad++;
      $display("FAIL clear_hold: got i1=%0d i2=%0d ctrl=%b stage=%b want 3 5 00 00", i1, i2, ctrl, stage);
    end
    total++;
    if (vcount !== 0) begin bad++; $display("FAIL clear_no_valid: got %0d want 0", vcount); end
    press_enter(4'd9);
    press_enter(4'd1);
    press_enter(4'd2);
    total++;
    if ({i1, i2, ctrl, stage} !== {4'd9, 4'd2, 2'b01, 2'b11} || vcount !== 1) begin
      bad++;
      $display("FAIL clear_fresh_entry: got i1=%0d i2=%0d ctrl=%b stage=%b v=%0d want 9 2 01 11 1",
               i1, i2, ctrl, stage, vcount);
    end
  endtask

  task automatic test_unary;
    press_enter(4'd0);
    vcount = 0;
    seen_b = 0;
    press_enter(4'd6);
    press_enter(4'b0111);
    total++;
    if ({i1, i2, ctrl, stage} !== {4'd6, 4'd0, 2'b11, 2'b11}) begin
      bad++;
      $display("FAIL unary_commit: got i1=%0d i2=%0d ctrl=%b stage=%b want 6 0 11 11", i1, i2, ctrl, stage);
    end
    total++;
    if (vcount !== 1 || seen_b !== 0) begin
      bad++;
      $display("FAIL unary_path: got valid=%0d seen_b=%0d want 1 0", vcount, seen_b);
    end
  endtask

  task automatic test_bounce;
    int change_at;
    int changes;
    logic [1:0] prev;
    sw = 4'd0;
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, 1'b0, 2);
      hold(1'b0, 1'b0, 2);
    end
    total++;
    if (stage !== 2'b11) begin bad++; $display("FAIL bounce_rejected: got stage %b want 11", stage); end
    btn_enter = 1'b1;
    change_at = -1;
    changes   = 0;
    prev      = stage;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (stage !== prev) begin
        changes++;
        if (change_at < 0) change_at = k;
      end
      prev = stage;
    end
    total++;
    if (change_at !== 8 || changes !== 1 || stage !== 2'b00) begin
      bad++;
      $display("FAIL bounce_latency: got change_at=%0d changes=%0d stage=%b want 8 1 00",
               change_at, changes, stage);
    end
    hold(1'b0, 1'b0, 10);
  endtask

  task automatic test_enter_and_clear;
    vcount = 0;
    press_enter(4'd1);
    total++;
    if (stage !== 2'b01) begin bad++; $display("FAIL both_setup: got %b want 01", stage); end
    sw = 4'd0;
    hold(1'b1, 1'b1, 12);
    hold(1'b0, 1'b0, 10);
    total++;
    if ({i1, i2, ctrl, stage} !== {4'd6, 4'd0, 2'b11, 2'b00} || vcount !== 0) begin
      bad++;
      $display("FAIL both_clear_wins: got i1=%0d i2=%0d ctrl=%b stage=%b v=%0d want 6 0 11 00 0",
               i1, i2, ctrl, stage, vcount);
    end
  endtask

  task automatic test_async_reset;
    press_enter(4'd4);
    press_enter(4'd0);
    total++;
    if (stage !== 2'b10) begin bad++; $display("FAIL rst_setup: got %b want 10", stage); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({i1, i2, ctrl, op_valid, stage} !== 15'd0) begin
      bad++;
      $display("FAIL async_reset: got i1=%0d i2=%0d ctrl=%b v=%b stage=%b want all 0",
               i1, i2, ctrl, op_valid, stage);
    end
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    hold(1'b0, 1'b0, 5);
    total++;
    if (stage !== 2'b00 || vcount !== 0) begin
      bad++;
      $display("FAIL after_reset: got stage=%b v=%0d want 00 0", stage, vcount);
    end
  endtask

  initial begin
    rst       = 1'b1;
    sw        = '0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    vcount    = 0;
    seen_b    = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_binary;
    test_clear_in_b;
    test_unary;
    test_bounce;
    test_enter_and_clear;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
